pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit adder; carry-chain split into STAGES equal chunks, one chunk resolved per pipeline stage.
- Supports add and subtract with carry/borrow in, valid/ready handshake with back-pressure.
- Sits between the ALU operand-select logic and the writeback path for multi-cycle arithmetic and wide (e.g. 64-bit) accumulation.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and carry-chain chunk count; 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- in_valid_in  input  1  operands valid.
- in_ready_out  output  1  block accepts operands this cycle.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- car_in  input  1  carry-in (add) / borrow-in (sub).
- sub_in  input  1  0 = add, 1 = subtract.
- out_valid_out  output  1  result valid.
- out_ready_in  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- car_out  output  1  carry-out of MSB (sub: 1 = no borrow).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Arithmetic: add -> {car_out,result} = a_in + b_in + car_in. Sub -> {car_out,result} = a_in + ~b_in + ~car_in, i.e. a - b - car_in; car_out is the raw adder carry.
- Transfer in: occurs when in_valid_in && in_ready_out; a, ~b/b, effective carry captured into stage 0.
- Stage k (0..STAGES-1): adds bits [k*CW +: CW] of A and B with the carry from stage k-1 (stage 0: effective carry-in). Registers the partial result, the carry, and the remaining unprocessed operand bits.
- Last stage drives result/car_out/out_valid_out directly from registers; no combinational path from inputs to outputs.
- Stall: advance = !out_valid_out || out_ready_in. in_ready_out = advance (combinational from out_ready_in only).
- Whole pipeline shifts together when advance=1; holds all stage data and valids when advance=0.
- Bubbles (stage valid=0) shift like data; they are not compressed.
- Latency: exactly STAGES cycles from accepted input to out_valid_out with no stall. Throughput: 1 op/cycle.
- Outputs remain stable while out_valid_out && !out_ready_in (AXI-style hold).
- Inputs not accepted (in_ready_out=0) are ignored; the source must hold them.
- STAGES=1: single register stage, latency 1.
- Reset (any time, including mid-operation): all stage valids=0, out_valid_out=0, result=0, car_out=0. In-flight operations are discarded. in_ready_out=1 during and after reset.
- Wrap-around: result modulo 2^WIDTH; overflow beyond car_out not signalled unless the optional feature is enabled.
- Simultaneous accept at the input and drain at the output in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro PIPELINED_ADDER_FLAGS_EN.
- Defined: adds outputs ovf_out (1 bit, signed overflow = carry into MSB XOR carry out of MSB, using the sub-adjusted operands) and zero_out (1 bit, result==0). Both are registered alongside result, reset to 0, and obey the same hold rule.
- Undefined: ports absent, no extra logic.

Test Plan:
- WIDTH=32, STAGES=4, add: a=FFFFFFFF, b=00000001, car=0 -> 4 cycles later result=00000000, car_out=1; carry propagates through all chunks.
- Sub: a=00000005, b=00000007, car=0 -> result=FFFFFFFE, car_out=0; with flags enabled ovf_out=0, zero_out=0.
- Back-to-back stream of 16 random ops with out_ready_in=1 -> 16 consecutive valid results in order, matching a behavioural model, in_ready_out stuck at 1.
- Back-pressure: out_ready_in=0 for 5 cycles while feeding -> in_ready_out=0 once out_valid_out=1, result held constant, no op lost or duplicated after release.
- Reset asserted asynchronously mid-stream with 3 ops in flight -> out_valid_out=0, result=0 immediately; the first post-reset op emerges after exactly STAGES cycles.
- WIDTH=64, STAGES=8 and WIDTH=32, STAGES=1: exhaustive 16-bit sweeps of each operand field against the reference model -> zero mismatches; flags: 7FFFFFFF+1 -> ovf_out=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-chunked add/sub with valid/ready back-pressure
// Ports: clk_in, rst_n_in (async, active-low); in_valid_in/in_ready_out with a_in, b_in,
// car_in, sub_in; out_valid_out/out_ready_in with result, car_out.
// Optional PIPELINED_ADDER_FLAGS_EN adds registered ovf_out (signed overflow) and zero_out.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             car_in,
  input  logic             sub_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] result,
  output logic             car_out
`ifdef PIPELINED_ADDER_FLAGS_EN
  ,
  output logic             ovf_out,
  output logic             zero_out
`endif
);
  localparam int CW = WIDTH / STAGES;
  logic adv;
  assign adv          = !out_valid_out || out_ready_in;
  assign in_ready_out = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // DW: operand bits still unprocessed on entry; PW: result bits resolved on exit
    localparam int DW = WIDTH - k * CW;
    localparam int PW = (k + 1) * CW;
    logic [DW-1:0] a_d, b_d;
    logic          c_d, v_d, c_q, v_q;
    logic [CW:0]   sum;
    logic [PW-1:0] s_n, s_q;
    if (k == 0) begin : g_head
      assign a_d = a_in;
      assign b_d = sub_in ? ~b_in : b_in;
      assign c_d = car_in ^ sub_in;
      assign v_d = in_valid_in;
      assign s_n = sum[CW-1:0];
    end else begin : g_body
      assign a_d = g_stage[k-1].g_ops.a_q;
      assign b_d = g_stage[k-1].g_ops.b_q;
      assign c_d = g_stage[k-1].c_q;
      assign v_d = g_stage[k-1].v_q;
      assign s_n = {sum[CW-1:0], g_stage[k-1].s_q};
    end
    assign sum = {1'b0, a_d[CW-1:0]} + {1'b0, b_d[CW-1:0]} + {{CW{1'b0}}, c_d};
    always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        c_q <= sum[CW];
        s_q <= s_n;
      end
    // Operands are shifted down as they go so each stage always works on its low chunk
    if (k < STAGES - 1) begin : g_ops
      logic [DW-CW-1:0] a_q, b_q;
      always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d[DW-1:CW];
          b_q <= b_d[DW-1:CW];
        end
    end
  end
  assign out_valid_out = g_stage[STAGES-1].v_q;
  assign result        = g_stage[STAGES-1].s_q;
  assign car_out       = g_stage[STAGES-1].c_q;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic ovf_d, zero_d;
  // a^b^sum at the MSB recovers the carry into the MSB
  assign ovf_d  = g_stage[STAGES-1].a_d[CW-1] ^ g_stage[STAGES-1].b_d[CW-1]
                ^ g_stage[STAGES-1].sum[CW-1] ^ g_stage[STAGES-1].sum[CW];
  assign zero_d = g_stage[STAGES-1].s_n == '0;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      ovf_out  <= 1'b0;
      zero_out <= 1'b0;
    end else if (adv) begin
      ovf_out  <= ovf_d;
      zero_out <= zero_d;
    end
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of pipelined_adder against an arithmetic model
module tb_pipelined_adder;
  localparam int S = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1, iv = 1'b0, ci = 1'b0, sb = 1'b0, ord = 1'b1;
  logic [63:0] a64 = '0, b64 = '0;
  logic        ird, ov, co, ird1, ov1, co1, ird2, ov2, co2;
  logic [31:0] res, res2;
  logic [63:0] res1;
`ifdef PIPELINED_ADDER_FLAGS_EN
  logic        ovf, zero, ovf1, zero1, ovf2, zero2;
  logic [1:0]  f0[$];
  logic [1:0]  fe;
`endif
  int          checks = 0, failures = 0;
  logic [64:0] q0[$], q1[$], q2[$];
  logic [64:0] e;
  logic        stall_p = 1'b0;
  logic [33:0] hold_p = '0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(S)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(iv), .in_ready_out(ird),
    .a_in(a64[31:0]), .b_in(b64[31:0]), .car_in(ci), .sub_in(sb),
    .out_valid_out(ov), .out_ready_in(ord), .result(res), .car_out(co)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .ovf_out(ovf), .zero_out(zero)
`endif
  );
  pipelined_adder #(.WIDTH(64), .STAGES(8)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(iv), .in_ready_out(ird1),
    .a_in(a64), .b_in(b64), .car_in(ci), .sub_in(sb),
    .out_valid_out(ov1), .out_ready_in(1'b1), .result(res1), .car_out(co1)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .ovf_out(ovf1), .zero_out(zero1)
`endif
  );
  pipelined_adder #(.WIDTH(32), .STAGES(1)) u2 (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(iv), .in_ready_out(ird2),
    .a_in(a64[31:0]), .b_in(b64[31:0]), .car_in(ci), .sub_in(sb),
    .out_valid_out(ov2), .out_ready_in(1'b1), .result(res2), .car_out(co2)
`ifdef PIPELINED_ADDER_FLAGS_EN
    , .ovf_out(ovf2), .zero_out(zero2)
`endif
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {carry_out, result}: add is a+b+c, sub is a-b-c with carry_out meaning "no borrow"
  function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input logic s);
    logic [64:0] m, x, y, r;
    m = (65'd1 << w) - 65'd1;
    x = {1'b0, a} & m;
    y = {1'b0, b} & m;
    r = s ? x - y - 65'(c) : x + y + 65'(c);
    return {s ? ~r[w] : r[w], r[63:0] & m[63:0]};
  endfunction

  // {signed_overflow, zero} of the 32-bit operation using true signed arithmetic
  function automatic logic [1:0] flags(input logic [31:0] a, input logic [31:0] b,
                                       input logic c, input logic s);
    longint t;
    t = s ? longint'($signed(a)) - longint'($signed(b)) - longint'(c)
          : longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    return {t > 64'sh7fffffff || t < -64'sh80000000, t[31:0] == 32'h0};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0: return 64'h0;
      1: return '1;
      2: return 64'h7fffffff_7fffffff;
      3: return 64'h80000000_80000000;
      4: return 64'h00000000_ffffffff;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_op();
    a64 = pick();
    b64 = pick();
    ci  = 1'($urandom_range(1));
    sb  = 1'($urandom_range(1));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
`ifdef PIPELINED_ADDER_FLAGS_EN
      f0.delete();
`endif
      stall_p = 1'b0;
    end else begin
      chk("ready_rule", ird, !ov || ord);
      chk("ready64", ird1, 1'b1);
      chk("ready_s1", ird2, 1'b1);
      if (stall_p) chk("hold", {ov, co, res}, hold_p);
      if (ov && ord) begin
        chk("out0_expected", q0.size() != 0, 1'b1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("out0", {co, res}, {e[64], e[31:0]});
        end
`ifdef PIPELINED_ADDER_FLAGS_EN
        if (f0.size() != 0) begin
          fe = f0.pop_front();
          chk("flags0", {ovf, zero}, fe);
        end
`endif
      end
      if (ov1) begin
        chk("out64_expected", q1.size() != 0, 1'b1);
        if (q1.size() != 0) chk("out64", {co1, res1}, q1.pop_front());
      end
      if (ov2) begin
        chk("out_s1_expected", q2.size() != 0, 1'b1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk("out_s1", {co2, res2}, {e[64], e[31:0]});
        end
      end
      if (iv && ird) begin
        q0.push_back(model(32, a64, b64, ci, sb));
`ifdef PIPELINED_ADDER_FLAGS_EN
        f0.push_back(flags(a64[31:0], b64[31:0], ci, sb));
`endif
      end
      if (iv && ird1) q1.push_back(model(64, a64, b64, ci, sb));
      if (iv && ird2) q2.push_back(model(32, a64, b64, ci, sb));
      stall_p = ov && !ord;
      hold_p  = {ov, co, res};
    end
  end

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                         input logic co_x, input logic [31:0] res_x, input logic [1:0] fl_x);
    @(posedge clk); #1;
    a64 = {32'h0, a};
    b64 = {32'h0, b};
    ci  = c;
    sb  = s;
    iv  = 1'b1;
    ord = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    for (int i = 1; i <= S; i++) begin
      @(negedge clk);
      chk("latency_valid", ov, i == S);
    end
    chk("directed", {co, res}, {co_x, res_x});
`ifdef PIPELINED_ADDER_FLAGS_EN
    chk("directed_flags", {ovf, zero}, fl_x);
`endif
  endtask

  task automatic stream(input int n, input int rdy_pct, input int vld_pct, input int st_lo, input int st_hi);
    int   sent = 0;
    logic acc = 1'b0;
    for (int cyc = 0; cyc < 4000 && sent < n; cyc++) begin
      @(posedge clk); #1;
      if (acc) sent++;
      if (acc || !iv) begin
        iv = sent < n && $urandom_range(99) < vld_pct;
        rand_op();
      end
      ord = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      acc = iv && ird;
    end
    chk("stream_done", sent, n);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    iv  = 1'b0;
    ord = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", ov, 1'b0);
    chk("rst_result", {co, res}, 33'h0);
    chk("rst_ready", ird, 1'b1);
    chk("rst_valid64", ov1, 1'b0);
    chk("rst_result64", {co1, res1}, 65'h0);
    chk("rst_valid_s1", ov2, 1'b0);
`ifdef PIPELINED_ADDER_FLAGS_EN
    chk("rst_flags", {ovf, zero}, 2'b00);
`endif
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_one(32'hffffffff, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 2'b01);
    run_one(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hfffffffe, 2'b00);
    run_one(32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 2'b10);
    run_one(32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'h00000000, 2'b01);
    run_one(32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'hffffffff, 2'b00);
    run_one(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h00000001, 2'b10);
    run_one(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h7fffffff, 2'b10);
    for (int cyc = 0; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      iv = cyc < 16;
      rand_op();
      @(negedge clk);
      chk("b2b_ready", ird, 1'b1);
      chk("b2b_valid", ov, cyc >= S && cyc < 16 + S);
    end
    stream(10, 100, 100, 4, 8);
    drain();
    chk("bp_no_loss", q0.size(), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      a64 = 64'h11111111 * (i + 1);
      b64 = 64'h01010101;
      ci  = 1'b0;
      sb  = 1'b0;
      iv  = 1'b1;
      ord = 1'b1;
      @(posedge clk); #1;
    end
    iv  = 1'b0;
    ord = 1'b0;
    #1;
    chk("pre_rst_valid", ov, 1'b1);
    chk("pre_rst_result", {co, res}, 33'h012121212);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov, 1'b0);
    chk("async_rst_result", {co, res}, 33'h0);
    chk("async_rst_ready", ird, 1'b1);
    chk("async_rst_valid64", ov1, 1'b0);
    chk("async_rst_valid_s1", ov2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_valid", ov, 1'b0);
    #1 rst_n = 1'b1;
    ord = 1'b1;
    run_one(32'h00000003, 32'h00000004, 1'b1, 1'b0, 1'b0, 32'h00000008, 2'b00);
    stream(300, 75, 80, -1, -1);
    drain();
    chk("final_empty0", q0.size(), 0);
    chk("final_empty64", q1.size(), 0);
    chk("final_empty_s1", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
